keypad_conditioner: RTL and testbench
=====================================

# keypad_conditioner

Input front-end for the synthesizer: conditions the 15 raw push-button lines (13 note keys, MODE, OCTAVE) before they reach the tone/waveform logic. It synchronizes each line, debounces all lines against a shared sample tick, and priority-encodes the note keys into a registered note index with a valid flag. It also emits single-cycle pulses on debounced MODE/OCTAVE presses and on any note change. It sits directly upstream of the oscillator/PWM path in `synth`, at the 10 MHz system clock.

## Interface
- `TICK_DIV`, default 10000 — debounce sample period in clk cycles; 10000 = 1 ms at 10 MHz; legal range 1..65535.
- `CNT_W`, default 16 — prescaler width; must satisfy 2^CNT_W ≥ TICK_DIV.
- `clk`  in  1  system clock, 10 MHz; all logic on rising edge.
- `NRST`  in  1  reset, asynchronous assert, active-low; one clock domain.
- `NOTES`  in  13  raw note keys, asynchronous; bit 0 = low C … bit 12 = high C.
- `MODE`  in  1  raw waveform-mode button, asynchronous.
- `OCTAVE`  in  1  raw octave/sound-gen button, asynchronous.
- `note_idx`  out  4  registered index of the pressed note, 0..12; 4'hF when none.
- `note_valid`  out  1  registered; 1 when any debounced note key is pressed.
- `note_chg`  out  1  one-cycle pulse when `note_idx` changes value.
- `mode_pulse`  out  1  one-cycle pulse on debounced MODE rising edge.
- `octave_pulse`  out  1  one-cycle pulse on debounced OCTAVE rising edge.

## Operation
- Synchronizer: a 2-FF chain per line (`s1`, `s2`), 15 bits wide. Reset value 0.
- Prescaler: `cnt` counts 0..TICK_DIV-1 and wraps to 0. `tick` = (`cnt` == TICK_DIV-1). With TICK_DIV=1, `tick` is high every cycle.
- Debounce, on each `tick` edge:
  - `samp` ← `s2`.
  - For each bit where `s2` == `samp`: `db[bit]` ← `s2`.
  - A bit changes only after two consecutive tick samples agree. A glitch shorter than one tick period never reaches `db`.
- Between ticks, `samp` and `db` hold.
- Priority encode on `db[12:0]`: the lowest set index wins. Simultaneous keys produce the lowest note. No key gives index 4'hF, valid 0.
- Output register (one cycle after `db`):
  - `note_idx` ← encode(`db[12:0]`).
  - `note_valid` ← |`db[12:0]`.
  - `note_chg` ← (encode(`db`) ≠ `note_idx`).
  - `mode_pulse` ← `db[13]` & ~`db13_q`.
  - `octave_pulse` ← `db[14]` & ~`db14_q`.
  - `db13_q` and `db14_q` are the previous-cycle copies of the debounced MODE and OCTAVE bits.
- Release events (falling debounced MODE/OCTAVE) produce no pulse.
- A note released while another is held switches `note_idx` to the next-lowest held key and fires `note_chg`.
- Reset values: `s1`, `s2`, `samp`, `db`, `cnt`, and the edge registers are 0. `note_idx` = 4'hF; `note_valid`, `note_chg`, `mode_pulse`, `octave_pulse` = 0.
- Reset mid-operation clears everything asynchronously. A button still held at release is treated as a new press: after debounce it yields `mode_pulse`/`octave_pulse` again, and `note_chg` fires when the held note becomes valid.

## Timing
- Let rising edge E1 be the first edge after an input change. Then `s2` updates at E2.
- With TICK_DIV=1:
  - `samp` updates at E3.
  - `db` updates at E4.
  - Outputs update at E5. Latency is 5 cycles.
  - An input held for ≤1 cycle is filtered.
- General case: `db` updates 2 cycles plus between TICK_DIV+1 and 2·TICK_DIV cycles after the input change. Outputs follow 1 cycle later.
- Each pulse is exactly 1 cycle wide. Pulse spacing is at least 2·TICK_DIV cycles for a bouncing button.
- All outputs are glitch-free registers. No combinational path exists from input to output.

## Test plan
- Power-on reset: assert NRST with random button inputs → `note_idx` = F, all other outputs 0, held through 2 clocks in reset and 1 clock after release.
- TICK_DIV=4, hold NOTES = 13'h0001 → within 2+8+1 cycles `note_idx` = 0, `note_valid` = 1, one `note_chg` pulse. Release → `note_idx` = F, `note_valid` = 0, one `note_chg` pulse.
- TICK_DIV=4, NOTES = 13'h1200 (A and high C) → `note_idx` = 9. Then drop bit 9 → `note_idx` = 12 with `note_chg`.
- TICK_DIV=4, MODE pulsed high for 3 cycles → no `mode_pulse`. MODE held 20 cycles → exactly one 1-cycle `mode_pulse`, and none on release.
- TICK_DIV=4, OCTAVE bounces at 1-cycle toggles for 10 cycles then settles high → exactly one `octave_pulse` after settling.
- Hold MODE and NOTES[4] debounced, pulse NRST low mid-cycle for 2 cycles, keep buttons held → outputs clear immediately, then after debounce `note_idx` = 4 with `note_chg`, and one new `mode_pulse`.

Source files
------------

// File: rtl/keypad_conditioner.sv
// Push-button front-end: 2-FF synchronizers, tick-sampled debounce, priority
// note encoder, and registered pulses for MODE/OCTAVE presses and note changes.
module keypad_conditioner #(
  parameter int unsigned TICK_DIV = 10000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic        clk,
  input  logic        NRST,
  input  logic [12:0] NOTES,
  input  logic        MODE,
  input  logic        OCTAVE,
  output logic [3:0]  note_idx,
  output logic        note_valid,
  output logic        note_chg,
  output logic        mode_pulse,
  output logic        octave_pulse
);

  logic [14:0]      raw;
  logic [14:0]      s1;
  logic [14:0]      s2;
  logic [14:0]      samp;
  logic [14:0]      db;
  logic [14:0]      differ;
  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic             db13_q;
  logic             db14_q;
  logic [3:0]       enc;

  assign raw    = {OCTAVE, MODE, NOTES};
  assign tick   = (cnt == CNT_W'(TICK_DIV - 1));
  // Bits whose current sample disagrees with the previous tick's sample keep db.
  assign differ = s2 ^ samp;

  always_comb begin
    enc = 4'hF;
    for (int unsigned i = 0; i < 13; i++) begin
      if (db[i] && (enc == 4'hF)) enc = 4'(i);
    end
  end

  always_ff @(posedge clk or negedge NRST) begin
    if (!NRST) begin
      s1           <= '0;
      s2           <= '0;
      samp         <= '0;
      db           <= '0;
      cnt          <= '0;
      db13_q       <= 1'b0;
      db14_q       <= 1'b0;
      note_idx     <= 4'hF;
      note_valid   <= 1'b0;
      note_chg     <= 1'b0;
      mode_pulse   <= 1'b0;
      octave_pulse <= 1'b0;
    end else begin
      s1  <= raw;
      s2  <= s1;
      cnt <= tick ? '0 : cnt + CNT_W'(1);
      if (tick) begin
        samp <= s2;
        db   <= (db & differ) | (s2 & ~differ);
      end
      db13_q       <= db[13];
      db14_q       <= db[14];
      note_idx     <= enc;
      note_valid   <= |db[12:0];
      note_chg     <= (enc != note_idx);
      mode_pulse   <= db[13] & ~db13_q;
      octave_pulse <= db[14] & ~db14_q;
    end
  end

endmodule

// File: tb/tb_keypad_conditioner.sv
// Bench for keypad_conditioner: TICK_DIV=1 and TICK_DIV=4 instances share stimulus;
// table vectors go through a scoreboard queue, corner cases are hand-written.
module tb_keypad_conditioner;

  logic        tb_clk = 1'b0;
  logic        NRST;
  logic [12:0] NOTES;
  logic        MODE;
  logic        OCTAVE;

  logic [3:0] idx1, idx4;
  logic       val1, val4, chg1, chg4, mp1, mp4, op1, op4;

  int total = 0;
  int bad   = 0;
  int c_chg1 = 0, c_chg4 = 0, c_m1 = 0, c_m4 = 0, c_o1 = 0, c_o4 = 0;

  always #5 tb_clk = ~tb_clk;

  keypad_conditioner #(.TICK_DIV(1), .CNT_W(4)) dut1 (
    .clk(tb_clk), .NRST(NRST), .NOTES(NOTES), .MODE(MODE), .OCTAVE(OCTAVE),
    .note_idx(idx1), .note_valid(val1), .note_chg(chg1),
    .mode_pulse(mp1), .octave_pulse(op1)
  );

  keypad_conditioner #(.TICK_DIV(4), .CNT_W(4)) dut4 (
    .clk(tb_clk), .NRST(NRST), .NOTES(NOTES), .MODE(MODE), .OCTAVE(OCTAVE),
    .note_idx(idx4), .note_valid(val4), .note_chg(chg4),
    .mode_pulse(mp4), .octave_pulse(op4)
  );

  // Pulse counters sampled on the falling edge; a 2-cycle pulse counts twice.
  always @(negedge tb_clk) begin
    if (chg1) c_chg1++;
    if (chg4) c_chg4++;
    if (mp1)  c_m1++;
    if (mp4)  c_m4++;
    if (op1)  c_o1++;
    if (op4)  c_o4++;
  end

  typedef struct {
    logic [12:0] notes;
    logic        mode;
    logic        octave;
    logic [3:0]  exp_idx;
    logic        exp_valid;
    int          exp_chg;
    int          exp_mode;
    int          exp_oct;
  } vec_t;

  vec_t vecs[12];
  vec_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge tb_clk);
      #1;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " idx1"}, idx1, 15);
    chk({tag, " val1"}, val1, 0);
    chk({tag, " chg1"}, chg1, 0);
    chk({tag, " mp1"},  mp1,  0);
    chk({tag, " op1"},  op1,  0);
    chk({tag, " idx4"}, idx4, 15);
    chk({tag, " val4"}, val4, 0);
    chk({tag, " chg4"}, chg4, 0);
    chk({tag, " mp4"},  mp4,  0);
    chk({tag, " op4"},  op4,  0);
  endtask

  initial begin
    int b1, b4, m1, m4, o1, o4;
    vec_t e;

    vecs[0]  = '{13'h0001, 1'b0, 1'b0, 4'd0,  1'b1, 1, 0, 0};
    vecs[1]  = '{13'h0000, 1'b0, 1'b0, 4'hF,  1'b0, 1, 0, 0};
    vecs[2]  = '{13'h1200, 1'b0, 1'b0, 4'd9,  1'b1, 1, 0, 0};
    vecs[3]  = '{13'h1000, 1'b0, 1'b0, 4'd12, 1'b1, 1, 0, 0};
    vecs[4]  = '{13'h1010, 1'b1, 1'b0, 4'd4,  1'b1, 1, 1, 0};
    vecs[5]  = '{13'h1010, 1'b0, 1'b1, 4'd4,  1'b1, 0, 0, 1};
    vecs[6]  = '{13'h0000, 1'b0, 1'b0, 4'hF,  1'b0, 1, 0, 0};
    vecs[7]  = '{13'h1FFF, 1'b1, 1'b1, 4'd0,  1'b1, 1, 1, 1};
    vecs[8]  = '{13'h1FFE, 1'b1, 1'b1, 4'd1,  1'b1, 1, 0, 0};
    vecs[9]  = '{13'h0800, 1'b0, 1'b0, 4'd11, 1'b1, 1, 0, 0};
    vecs[10] = '{13'h0800, 1'b0, 1'b0, 4'd11, 1'b1, 0, 0, 0};
    vecs[11] = '{13'h0000, 1'b0, 1'b0, 4'hF,  1'b0, 1, 0, 0};

    // Power-on reset with random buttons
    NRST   = 1'b0;
    NOTES  = 13'($urandom);
    MODE   = 1'($urandom);
    OCTAVE = 1'($urandom);
    cyc(2);
    chk_idle("reset");
    NRST = 1'b1;
    cyc(1);
    chk_idle("post-reset");
    NOTES = '0; MODE = 1'b0; OCTAVE = 1'b0;
    cyc(20);
    chk_idle("idle");

    // Table vectors through the scoreboard
    for (int i = 0; i < 12; i++) begin
      NOTES = vecs[i].notes; MODE = vecs[i].mode; OCTAVE = vecs[i].octave;
      exp_q.push_back(vecs[i]);
      b1 = c_chg1; b4 = c_chg4; m1 = c_m1; m4 = c_m4; o1 = c_o1; o4 = c_o4;
      cyc(14);
      if (exp_q.size() == 0) begin
        chk("scoreboard empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("v%0d idx1", i), idx1, e.exp_idx);
        chk($sformatf("v%0d val1", i), val1, e.exp_valid);
        chk($sformatf("v%0d chg1", i), c_chg1 - b1, e.exp_chg);
        chk($sformatf("v%0d mode1", i), c_m1 - m1, e.exp_mode);
        chk($sformatf("v%0d oct1", i), c_o1 - o1, e.exp_oct);
        chk($sformatf("v%0d idx4", i), idx4, e.exp_idx);
        chk($sformatf("v%0d val4", i), val4, e.exp_valid);
        chk($sformatf("v%0d chg4", i), c_chg4 - b4, e.exp_chg);
        chk($sformatf("v%0d mode4", i), c_m4 - m4, e.exp_mode);
        chk($sformatf("v%0d oct4", i), c_o4 - o4, e.exp_oct);
      end
    end

    // Exact 5-cycle latency with TICK_DIV=1
    NOTES = 13'h0004;
    cyc(4);
    chk("lat E4 idx1", idx1, 15);
    cyc(1);
    chk("lat E5 idx1", idx1, 2);
    chk("lat E5 chg1", chg1, 1);
    cyc(1);
    chk("lat E6 chg1", chg1, 0);
    NOTES = '0;
    cyc(14);

    // 1-cycle glitch filtered by both
    b1 = c_chg1; b4 = c_chg4;
    NOTES = 13'h0008;
    cyc(1);
    NOTES = '0;
    cyc(14);
    chk("glitch chg1", c_chg1 - b1, 0);
    chk("glitch chg4", c_chg4 - b4, 0);
    chk("glitch idx1", idx1, 15);

    // 3-cycle MODE blip filtered at TICK_DIV=4
    m4 = c_m4;
    MODE = 1'b1;
    cyc(3);
    MODE = 1'b0;
    cyc(16);
    chk("blip mode4", c_m4 - m4, 0);

    // MODE held 20 cycles: one pulse, none on release
    m1 = c_m1; m4 = c_m4;
    MODE = 1'b1;
    cyc(20);
    MODE = 1'b0;
    cyc(16);
    chk("hold mode1", c_m1 - m1, 1);
    chk("hold mode4", c_m4 - m4, 1);

    // OCTAVE bounce then settle high
    o1 = c_o1; o4 = c_o4;
    for (int i = 0; i < 10; i++) begin
      OCTAVE = ~OCTAVE;
      cyc(1);
    end
    OCTAVE = 1'b1;
    cyc(20);
    chk("bounce oct1", c_o1 - o1, 1);
    chk("bounce oct4", c_o4 - o4, 1);
    OCTAVE = 1'b0;
    cyc(16);

    // Reset mid-operation with MODE and NOTES[4] held
    NOTES = 13'h0010; MODE = 1'b1;
    cyc(16);
    chk("pre-rst idx4", idx4, 4);
    chk("pre-rst idx1", idx1, 4);
    #2;
    NRST = 1'b0;
    #1;
    chk("async clr idx1", idx1, 15);
    chk("async clr idx4", idx4, 15);
    chk("async clr val4", val4, 0);
    repeat (2) @(posedge tb_clk);
    #3;
    b1 = c_chg1; b4 = c_chg4; m1 = c_m1; m4 = c_m4;
    NRST = 1'b1;
    cyc(16);
    chk("rerun idx1", idx1, 4);
    chk("rerun idx4", idx4, 4);
    chk("rerun val4", val4, 1);
    chk("rerun chg1", c_chg1 - b1, 1);
    chk("rerun chg4", c_chg4 - b4, 1);
    chk("rerun mode1", c_m1 - m1, 1);
    chk("rerun mode4", c_m4 - m4, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
